// File: rtl/memstage.sv
// memstage: rv32i memory-access stage. Issues loads/stores on a single-outstanding
// req/gnt/rvalid data bus and emits one writeback bundle per accepted instruction.
module memstage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  mem_op_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_write_o,
  output logic [31:0] wb_data_o,
  output logic        fault_o
);
  // state | meaning
  // IDLE  | accepting bundles, bus quiet
  // REQ   | dmem request held until grant
  // WAIT  | load granted, waiting for rvalid
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_q, state_d;

  logic        is_load, is_store, accept, bad_f3, misaligned, fault_c, start_mem;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        write_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign ready_o  = (state_q == IDLE);
  assign accept   = valid_i && ready_o;
  assign is_load  = (mem_op_i == 2'b01);
  assign is_store = (mem_op_i == 2'b10);

  always_comb begin
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    if (is_load)
      bad_f3 = !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (is_store)
      bad_f3 = !(funct3_i inside {3'b000, 3'b001, 3'b010});
    case (funct3_i[1:0])
      2'b01:   misaligned = alu_result_i[0];
      2'b10:   misaligned = |alu_result_i[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign fault_c   = (is_load || is_store) && (bad_f3 || misaligned);
  assign start_mem = accept && (is_load || is_store) && !fault_c;

  // Byte enables follow the access size for loads too; write data only matters for stores.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_c    = 4'b0001 << alu_result_i[1:0];
        wdata_c = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_c    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
    if (!is_store) wdata_c = '0;
  end

  always_comb begin
    byte_sel = dmem_rdata_i[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'b0, byte_sel};
      3'b101:  load_data = {16'b0, half_sel};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_mem) state_d = REQ;
      REQ:     if (dmem_gnt_i) state_d = dmem_we_o ? IDLE : WAIT;
      WAIT:    if (dmem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_write_o   <= 1'b0;
      wb_data_o    <= '0;
      fault_o      <= 1'b0;
      lane_q       <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      write_q      <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      fault_o    <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (fault_c) begin
            wb_valid_o <= 1'b1;
            fault_o    <= 1'b1;
            wb_rd_o    <= rd_i;
            wb_write_o <= 1'b0;
            wb_data_o  <= '0;
          end else if (start_mem) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= is_store;
            dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
            dmem_be_o    <= be_c;
            dmem_wdata_o <= wdata_c;
            lane_q       <= alu_result_i[1:0];
            f3_q         <= funct3_i;
            rd_q         <= rd_i;
            write_q      <= reg_write_i && (rd_i != 5'd0);
          end else begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= rd_i;
            wb_write_o <= reg_write_i && (rd_i != 5'd0);
            wb_data_o  <= alu_result_i;
          end
        end
        REQ: if (dmem_gnt_i) begin
          dmem_req_o   <= 1'b0;
          dmem_we_o    <= 1'b0;
          dmem_be_o    <= '0;
          dmem_wdata_o <= '0;
          if (dmem_we_o) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= rd_q;
            wb_write_o <= 1'b0;
            wb_data_o  <= '0;
          end
        end
        WAIT: if (dmem_rvalid_i) begin
          wb_valid_o <= 1'b1;
          wb_rd_o    <= rd_q;
          wb_write_o <= write_q;
          wb_data_o  <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memstage.sv
// Self-checking bench for memstage: directed bundles, a bus responder, and a
// behavioural model of writeback bundles and bus requests.
module tb_memstage;
  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, reg_write_i;
  logic [31:0] alu_result_i, store_data_i;
  logic [1:0]  mem_op_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        wb_valid_o, wb_write_o, fault_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  always #5 clk_i = ~clk_i;

  memstage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .mem_op_i(mem_op_i),
    .funct3_i(funct3_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_write_o(wb_write_o),
    .wb_data_o(wb_data_o), .fault_o(fault_o)
  );

  typedef struct {
    bit          fault;
    bit          write;
    bit          chk_data;
    bit          imm;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          we;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   acc_q[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   gnt_dly = 0, rv_dly = 1, done_cyc = 0, last_wb_cyc = 0;
  int   wb_count = 0, fault_count = 0, req_cycles = 0;
  logic [31:0] rdata_cfg = '0, last_wb_data = '0;
  logic        last_wb_write = 1'b0;
  bus_t        last_bus;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected bundle and bus request straight from the ISA rules.
  function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rdata, input logic [4:0] rd,
                                input logic rw, output exp_t e, output bus_t b,
                                output bit has_bus);
    int          size;
    int unsigned off;
    logic [31:0] v, mask;
    has_bus    = 1'b0;
    b          = '{default: '0};
    e.fault    = 1'b0;
    e.chk_data = 1'b1;
    e.imm      = 1'b1;
    e.rd       = rd;
    e.write    = rw && (rd != 5'd0);
    e.data     = a;
    if (op != 2'b01 && op != 2'b10) return;
    size = 0;
    if (f3 == 3'd0 || (op == 2'b01 && f3 == 3'd4)) size = 1;
    else if (f3 == 3'd1 || (op == 2'b01 && f3 == 3'd5)) size = 2;
    else if (f3 == 3'd2) size = 4;
    off = a % 4;
    if (size == 0 || (off % size) != 0) begin
      e.fault = 1'b1;
      e.write = 1'b0;
      e.data  = '0;
      return;
    end
    has_bus = 1'b1;
    b.addr  = a - off;
    b.we    = (op == 2'b10);
    b.be    = 4'(((1 << size) - 1) << off);
    e.imm   = 1'b0;
    if (op == 2'b10) begin
      b.wdata    = (size == 1) ? (sd & 32'hFF) * 32'h01010101 :
                   (size == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
      e.write    = 1'b0;
      e.chk_data = 1'b0;
    end else begin
      mask = (size == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * size)) - 32'd1;
      v    = (rdata >> (8 * off)) & mask;
      if (f3 < 3'd4 && size < 4 && v >= (32'd1 << (8 * size - 1)))
        v = v - (32'd1 << (8 * size));
      e.data = v;
    end
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                       input int gd, input int rvd, input logic [31:0] rdat,
                       output int acc, output int low);
    exp_t e;
    bus_t b;
    bit   hb;
    model(op, f3, a, sd, rdat, rd, rw, e, b, hb);
    exp_q.push_back(e);
    if (hb) bus_q.push_back(b);
    if (op == 2'b01 || op == 2'b10) begin
      gnt_dly   = gd;
      rv_dly    = rvd;
      rdata_cfg = rdat;
    end
    valid_i      = 1'b1;
    mem_op_i     = op;
    funct3_i     = f3;
    alu_result_i = a;
    store_data_i = sd;
    rd_i         = rd;
    reg_write_i  = rw;
    low = 0;
    @(negedge clk_i);
    while (!ready_o && low < 200) begin
      low++;
      @(negedge clk_i);
    end
    check("accept_timeout", ready_o, 1);
    acc = cyc;
    acc_q.push_back(cyc);
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input logic [4:0] rd, input int gd,
                      input int rvd, input logic [31:0] rdat);
    int acc, low;
    drive(op, f3, a, sd, rd, 1'b1, gd, rvd, rdat, acc, low);
  endtask

  task automatic drain();
    int n = 0;
    valid_i  = 1'b0;
    mem_op_i = 2'b00;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin : responder
    bus_t b;
    int   n;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      if (dmem_req_o && !rst_i) begin
        if (bus_q.size() == 0) begin
          check("unexpected_req", dmem_req_o, 0);
        end else begin
          b = bus_q.pop_front();
          n = 0;
          while (1) begin
            check("bus_addr", dmem_addr_o, b.addr);
            check("bus_be", dmem_be_o, b.be);
            check("bus_we", dmem_we_o, b.we);
            if (b.we) check("bus_wdata", dmem_wdata_o, b.wdata);
            n++;
            if (n > gnt_dly || !dmem_req_o) break;
            @(negedge clk_i);
          end
          req_cycles = n;
          last_bus   = b;
          dmem_gnt_i = 1'b1;
          done_cyc   = cyc;
          @(negedge clk_i);
          dmem_gnt_i = 1'b0;
          check("req_drop", dmem_req_o, 0);
          if (!b.we && rv_dly > 0) begin
            repeat (rv_dly - 1) @(negedge clk_i);
            dmem_rdata_i  = rdata_cfg;
            dmem_rvalid_i = 1'b1;
            done_cyc      = cyc;
            @(negedge clk_i);
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = '0;
          end
        end
      end
    end
  end

  initial begin : compare
    exp_t e;
    int   a;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (!dmem_req_o)
          check("idle_bus_zero", 32'(dmem_we_o) | 32'(dmem_be_o) | dmem_wdata_o, 0);
        if (wb_valid_o) begin
          wb_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_wb", wb_valid_o, 0);
          end else begin
            e = exp_q.pop_front();
            a = (acc_q.size() != 0) ? acc_q.pop_front() : -10;
            check("wb_rd", wb_rd_o, e.rd);
            check("wb_write", wb_write_o, e.write);
            check("wb_fault", fault_o, e.fault);
            if (e.chk_data) check("wb_data", wb_data_o, e.data);
            check("wb_cycle", cyc, e.imm ? a + 1 : done_cyc + 1);
          end
          last_wb_cyc   = cyc;
          last_wb_data  = wb_data_o;
          last_wb_write = wb_write_o;
        end else begin
          check("fault_without_wb", fault_o, 0);
        end
        if (fault_o) fault_count++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin : main
    int acc, low, acc2, low2, wbc, fc;
    rst_i        = 1'b1;
    valid_i      = 1'b0;
    mem_op_i     = 2'b00;
    funct3_i     = 3'b000;
    alu_result_i = '0;
    store_data_i = '0;
    rd_i         = '0;
    reg_write_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", ready_o, 1);
    check("rst_req", dmem_req_o, 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_rd", wb_rd_o, 0);
    check("rst_wb_write", wb_write_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_fault", fault_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // ALU results back to back, then op 11 with rd=0
    wbc = wb_count;
    send(2'b00, 3'd0, 32'd1, 32'd0, 5'd5, 0, 0, 0);
    send(2'b00, 3'd0, 32'd2, 32'd0, 5'd5, 0, 0, 0);
    send(2'b00, 3'd0, 32'd3, 32'd0, 5'd5, 0, 0, 0);
    send(2'b11, 3'd0, 32'd7, 32'd0, 5'd0, 0, 0, 0);
    drain();
    check("alu_count", wb_count - wbc, 4);
    check("alu_rd0_data", last_wb_data, 32'd7);
    check("alu_rd0_write", last_wb_write, 0);

    // Stores
    send(2'b10, 3'd0, 32'h103, 32'hAB, 5'd9, 3, 0, 0);
    drain();
    check("sb_addr", last_bus.addr, 32'h100);
    check("sb_be", last_bus.be, 4'b1000);
    check("sb_wdata", last_bus.wdata, 32'hABABABAB);
    check("sb_req_cycles", req_cycles, 4);
    check("sb_wb_write", last_wb_write, 0);
    send(2'b10, 3'd1, 32'h102, 32'h12345678, 5'd3, 0, 0, 0);
    drain();
    check("sh_be", last_bus.be, 4'b1100);
    check("sh_wdata", last_bus.wdata, 32'h56785678);
    send(2'b10, 3'd2, 32'h200, 32'hCAFEF00D, 5'd3, 1, 0, 0);
    drain();

    // Loads
    send(2'b01, 3'd0, 32'h201, 32'd0, 5'd4, 0, 1, 32'h00008000);
    drain();
    check("lb_data", last_wb_data, 32'hFFFFFF80);
    send(2'b01, 3'd4, 32'h201, 32'd0, 5'd4, 0, 1, 32'h00008000);
    drain();
    check("lbu_data", last_wb_data, 32'h00000080);
    send(2'b01, 3'd1, 32'h202, 32'd0, 5'd4, 0, 2, 32'h80010000);
    drain();
    check("lh_data", last_wb_data, 32'hFFFF8001);
    send(2'b01, 3'd5, 32'h202, 32'd0, 5'd4, 1, 1, 32'h80010000);
    drain();
    check("lhu_data", last_wb_data, 32'h00008001);
    send(2'b01, 3'd2, 32'h300, 32'd0, 5'd0, 2, 3, 32'h12345678);
    drain();
    check("lw_data", last_wb_data, 32'h12345678);
    check("lw_rd0_write", last_wb_write, 0);

    // Faults: misaligned and unsupported funct3
    fc = fault_count;
    send(2'b01, 3'd2, 32'h302, 32'd0, 5'd6, 0, 1, 0);
    send(2'b01, 3'd3, 32'h300, 32'd0, 5'd6, 0, 1, 0);
    send(2'b10, 3'd1, 32'h101, 32'd0, 5'd6, 0, 1, 0);
    send(2'b10, 3'd4, 32'h100, 32'd0, 5'd6, 0, 1, 0);
    drain();
    check("fault_count", fault_count - fc, 4);
    check("fault_wb_write", last_wb_write, 0);
    check("fault_wb_data", last_wb_data, 0);

    // Load with slow rvalid while the next bundle waits with valid_i held high
    drive(2'b01, 3'd2, 32'h400, 32'd0, 5'd6, 1'b1, 1, 5, 32'hDEADBEEF, acc, low);
    drive(2'b00, 3'd0, 32'h55, 32'd0, 5'd7, 1'b1, 0, 0, 0, acc2, low2);
    drain();
    check("held_ready_low", low2, 7);
    check("held_accept_cycle", acc2 - acc, 8);
    check("held_last_data", last_wb_data, 32'h55);

    // Reset while waiting for rvalid, then a late rvalid
    drive(2'b01, 3'd2, 32'h500, 32'd0, 5'd8, 1'b1, 0, 0, 0, acc, low);
    valid_i  = 1'b0;
    mem_op_i = 2'b00;
    @(negedge clk_i);
    @(negedge clk_i);
    check("wait_ready_low", ready_o, 0);
    rst_i = 1'b1;
    exp_q.delete();
    acc_q.delete();
    bus_q.delete();
    wbc = wb_count;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_mid_req", dmem_req_o, 0);
    check("rst_mid_ready", ready_o, 1);
    dmem_rdata_i  = 32'h11111111;
    dmem_rvalid_i = 1'b1;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_no_wb", wb_count, wbc);
    check("rst_after_req", dmem_req_o, 0);
    check("rst_after_ready", ready_o, 1);
    @(posedge clk_i);
    #1;
    send(2'b00, 3'd0, 32'h77, 32'd0, 5'd2, 0, 0, 0);
    drain();
    check("post_rst_data", last_wb_data, 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
